// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage and the memory.
// One request is outstanding at a time and completes with a single-cycle mem_ack.
interface mem_stage_if #(
  parameter int DATA_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores on the memory bus, stalls upstream while an access is
// outstanding, and fills the MEM/WB register. An access with no ack after 256 wait cycles is dropped.
module mem_stage #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        Rd,
  input  logic [1:0]        MemToReg,
  input  logic              RegWrite,
  input  logic              MemWrite,
  input  logic              read_enable,
  input  logic              ChooseRd,
  mem_stage_if.master       mem,
  output logic              stall,
  output logic [DATA_W-1:0] ALUresultout,
  output logic [DATA_W-1:0] ReadDataout,
  output logic [4:0]        Rdout,
  output logic [1:0]        MemToRegout,
  output logic              RegWriteout,
  output logic              ChooseRdout,
  output logic              mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              memop;
  logic              cap_en;
  logic              use_rdata;
  logic              timeout;

  logic [DATA_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              we_p0;

  logic [DATA_W-1:0] alu_p1;
  logic [DATA_W-1:0] rdata_p1;
  logic [4:0]        rd_p1;
  logic [1:0]        mtr_p1;
  logic              rw_p1;
  logic              crd_p1;

  assign memop = MemWrite | read_enable;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    stall     = 1'b0;
    cap_en    = 1'b0;
    use_rdata = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          stall   = 1'b1;
          cap_en  = 1'b1;
          cnt_d   = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // An ack in the final wait cycle still completes the access normally.
        if (mem.mem_ack) begin
          use_rdata = ~we_p0;
          state_d   = IDLE;
        end else if (cnt_q == 8'hFF) begin
          timeout = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Capture stage: request fields frozen for the whole BUSY interval.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      addr_p0  <= ALUresult;
      wdata_p0 <= WriteData;
      we_p0    <= MemWrite;
    end
  end

  assign mem.mem_req   = (state_q == BUSY);
  assign mem.mem_we    = (state_q == BUSY) & we_p0;
  assign mem.mem_addr  = (state_q == BUSY) ? addr_p0  : '0;
  assign mem.mem_wdata = (state_q == BUSY) ? wdata_p0 : '0;

  // MEM/WB stage: a stalled cycle writes a bubble so nothing retires twice.
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      alu_p1   <= '0;
      rdata_p1 <= '0;
      rd_p1    <= '0;
      mtr_p1   <= '0;
      rw_p1    <= 1'b0;
      crd_p1   <= 1'b0;
    end else begin
      alu_p1   <= ALUresult;
      rdata_p1 <= use_rdata ? mem.mem_rdata : '0;
      rd_p1    <= Rd;
      mtr_p1   <= MemToReg;
      rw_p1    <= RegWrite & ~timeout;
      crd_p1   <= ChooseRd;
    end
  end

  assign ALUresultout = alu_p1;
  assign ReadDataout  = rdata_p1;
  assign Rdout        = rd_p1;
  assign MemToRegout  = mtr_p1;
  assign RegWriteout  = rw_p1;
  assign ChooseRdout  = crd_p1;
  assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a driver issues EX/MEM ops and queues the expected MEM/WB contents,
// a monitor pops and compares on every cycle the stage advances, and a memory model acks requests.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ALUresult, WriteData;
  logic [4:0]  Rd;
  logic [1:0]  MemToReg;
  logic        RegWrite, MemWrite, read_enable, ChooseRd;
  logic        stall;
  logic [63:0] ALUresultout, ReadDataout;
  logic [4:0]  Rdout;
  logic [1:0]  MemToRegout;
  logic        RegWriteout, ChooseRdout, mem_err;

  mem_stage_if #(.DATA_W(64)) bus ();

  mem_stage #(.DATA_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .ALUresult    (ALUresult),
    .WriteData    (WriteData),
    .Rd           (Rd),
    .MemToReg     (MemToReg),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .read_enable  (read_enable),
    .ChooseRd     (ChooseRd),
    .mem          (bus),
    .stall        (stall),
    .ALUresultout (ALUresultout),
    .ReadDataout  (ReadDataout),
    .Rdout        (Rdout),
    .MemToRegout  (MemToRegout),
    .RegWriteout  (RegWriteout),
    .ChooseRdout  (ChooseRdout),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] rdat;
    logic [4:0]  rd;
    logic [1:0]  mtr;
    logic        rw;
    logic        crd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   out_pending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory model: ack after lat BUSY cycles (0 = never), or always when ack_force is set.
  int          lat = 0;
  int          busy_n = 0;
  int          mreq_n = 0;
  int          mwe_n = 0;
  bit          ack_force = 1'b0;
  bit          addr_moved = 1'b0;
  logic [63:0] rdata_cfg = '0;
  logic [63:0] seen_addr = '0;
  logic [63:0] seen_wdata = '0;

  always @(posedge clk) begin
    #2;
    if (bus.mem_req) begin
      busy_n++;
      mreq_n++;
      if (bus.mem_we) mwe_n++;
      if (busy_n > 1 && (bus.mem_addr !== seen_addr || bus.mem_wdata !== seen_wdata))
        addr_moved = 1'b1;
      seen_addr   = bus.mem_addr;
      seen_wdata  = bus.mem_wdata;
      bus.mem_ack = ack_force || (lat != 0 && busy_n == lat);
    end else begin
      busy_n      = 0;
      bus.mem_ack = ack_force;
    end
    bus.mem_rdata = bus.mem_ack ? rdata_cfg : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  // Monitor: the MEM/WB register takes a new entry after every non-stalled, non-reset cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      out_pending = 1'b0;
    end else begin
      if (out_pending) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mwb_unexpected actual=ALUresultout %0h required=no entry", ALUresultout);
        end else begin
          e = q.pop_front();
          chk("mwb_alu",  ALUresultout, e.alu);
          chk("mwb_rdat", ReadDataout,  e.rdat);
          chk("mwb_rd",   64'(Rdout),       64'(e.rd));
          chk("mwb_mtr",  64'(MemToRegout), 64'(e.mtr));
          chk("mwb_rw",   64'(RegWriteout), 64'(e.rw));
          chk("mwb_crd",  64'(ChooseRdout), 64'(e.crd));
        end
      end
      out_pending = !stall && !reset;
    end
  end

  task automatic issue(input logic [63:0] alu, input logic [63:0] wd, input logic [4:0] rd,
                       input logic [1:0] mtr, input logic rw, input logic mw, input logic re,
                       input logic crd, input int l, input logic [63:0] rdat,
                       input logic [63:0] exp_rdat, input logic exp_rw, output int nstall);
    exp_t e;
    bit   done;
    ALUresult = alu; WriteData = wd; Rd = rd; MemToReg = mtr;
    RegWrite = rw; MemWrite = mw; read_enable = re; ChooseRd = crd;
    lat = l; rdata_cfg = rdat;
    mreq_n = 0; mwe_n = 0; addr_moved = 1'b0;
    e = '{alu: alu, rdat: exp_rdat, rd: rd, mtr: mtr, rw: exp_rw, crd: crd};
    q.push_back(e);
    nstall = 0;
    done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      nstall++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL op_complete actual=stalled %0d cycles required=completion", nstall);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op_chk(input string n, input int nst, input int exp_st, input int exp_req,
                        input int exp_we, input logic [63:0] exp_addr, input logic [63:0] exp_wd);
    chk({n, "_stall_cycles"}, 64'(nst),    64'(exp_st));
    chk({n, "_req_cycles"},   64'(mreq_n), 64'(exp_req));
    chk({n, "_we_cycles"},    64'(mwe_n),  64'(exp_we));
    if (exp_req > 0) begin
      chk({n, "_addr"},       seen_addr,  exp_addr);
      chk({n, "_wdata"},      seen_wdata, exp_wd);
      chk({n, "_bus_stable"}, 64'(addr_moved), 64'd0);
    end
  endtask

  task automatic drain();
    ALUresult = '0; WriteData = '0; Rd = '0; MemToReg = '0;
    RegWrite = 1'b0; MemWrite = 1'b0; read_enable = 1'b0; ChooseRd = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
  endtask

  task automatic chk_mwb_zero(input string n);
    chk({n, "_alu"},  ALUresultout, 64'd0);
    chk({n, "_rdat"}, ReadDataout,  64'd0);
    chk({n, "_ctl"},  64'({Rdout, MemToRegout, RegWriteout, ChooseRdout}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    ALUresult = '0; WriteData = '0; Rd = '0; MemToReg = '0;
    RegWrite = 1'b0; MemWrite = 1'b0; read_enable = 1'b0; ChooseRd = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_mwb_zero("rst");
    chk("rst_mem_err", 64'(mem_err), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Plain ALU ops pass straight through with one cycle of latency.
    issue(64'h10, 64'h0, 5'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 64'h0, 64'h0, 1'b1, n);
    op_chk("alu1", n, 0, 0, 0, 64'h0, 64'h0);
    issue(64'hFFFF_0000_1234_5678, 64'h0, 5'd31, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 0, 64'h0, 64'h0, 1'b1, n);
    op_chk("alu2", n, 0, 0, 0, 64'h0, 64'h0);

    // Load acked in the third BUSY cycle.
    issue(64'h100, 64'h77, 5'd5, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 3, 64'hDEAD, 64'hDEAD, 1'b1, n);
    op_chk("load", n, 3, 3, 0, 64'h100, 64'h77);

    // Store acked in the first BUSY cycle; returned data must not appear.
    issue(64'h200, 64'h55, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 64'h1234, 64'h0, 1'b0, n);
    op_chk("store", n, 1, 1, 1, 64'h200, 64'h55);

    // Write and read both requested: treated as a write.
    issue(64'h208, 64'hAA, 5'd7, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 2, 64'hBEEF, 64'h0, 1'b1, n);
    op_chk("wr_rd", n, 2, 2, 2, 64'h208, 64'hAA);

    // Back-to-back loads each pay the IDLE stall cycle.
    issue(64'h300, 64'h0, 5'd8, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 64'h1111, 64'h1111, 1'b1, n);
    op_chk("b2b_a", n, 1, 1, 0, 64'h300, 64'h0);
    issue(64'h308, 64'h0, 5'd9, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 64'h2222, 64'h2222, 1'b1, n);
    op_chk("b2b_b", n, 1, 1, 0, 64'h308, 64'h0);

    // An ack while IDLE changes nothing.
    ack_force = 1'b1;
    issue(64'h44, 64'h0, 5'd9, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 0, 64'h9999, 64'h0, 1'b1, n);
    op_chk("idle_ack", n, 0, 0, 0, 64'h0, 64'h0);
    ack_force = 1'b0;

    // Ack arriving in the last wait cycle beats the timeout.
    issue(64'h380, 64'h0, 5'd10, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 256, 64'hCAFE, 64'hCAFE, 1'b1, n);
    op_chk("late_ack", n, 256, 256, 0, 64'h380, 64'h0);
    chk("late_ack_err", 64'(mem_err), 64'd0);

    // No ack at all: timeout after 256 BUSY cycles, write-back suppressed.
    issue(64'h400, 64'h0, 5'd12, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 64'h0, 64'h0, 1'b0, n);
    op_chk("timeout", n, 256, 256, 0, 64'h400, 64'h0);
    chk("timeout_err", 64'(mem_err), 64'd1);
    chk("timeout_idle", 64'(bus.mem_req), 64'd0);
    issue(64'h48, 64'h0, 5'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 64'h0, 64'h0, 1'b1, n);
    chk("err_sticky", 64'(mem_err), 64'd1);
    drain();

    // Reset in the middle of an outstanding load, then a stray ack.
    ALUresult = 64'h500; Rd = 5'd4; RegWrite = 1'b1; read_enable = 1'b1;
    lat = 0; rdata_cfg = 64'h7777;
    @(negedge clk);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("mid_busy_req", 64'(bus.mem_req), 64'd1);
    reset = 1'b1;
    ALUresult = '0; Rd = '0; RegWrite = 1'b0; read_enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ack_force = 1'b1;
    @(negedge clk);
    chk("rst_busy_req", 64'(bus.mem_req), 64'd0);
    chk("rst_busy_we", 64'(bus.mem_we), 64'd0);
    chk("rst_busy_addr", bus.mem_addr, 64'd0);
    chk("rst_busy_stall", 64'(stall), 64'd0);
    chk("rst_busy_err", 64'(mem_err), 64'd0);
    chk_mwb_zero("rst_busy");
    @(posedge clk); #1;
    @(negedge clk);
    chk("late_ack_req", 64'(bus.mem_req), 64'd0);
    chk_mwb_zero("late_ack_ignored");
    ack_force = 1'b0;
    @(posedge clk); #1;

    mon_en = 1'b1;
    issue(64'h66, 64'h0, 5'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 64'h0, 64'h0, 1'b1, n);
    op_chk("after_rst", n, 0, 0, 0, 64'h0, 64'h0);
    drain();
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
